// File: rtl/branch_resolve_ctrl_if.sv
// EX-stage branch handoff: one branch per valid/ready handshake into the resolver.
interface branch_resolve_ctrl_if;
  logic        br_valid;
  logic        br_ready;
  logic [31:0] br_pc;
  logic [31:0] br_imm;
  logic [31:0] br_rs1;
  logic [31:0] br_rs2;
  logic [2:0]  br_funct3;
  logic        br_pred_taken;

  modport master (
    output br_valid, br_pc, br_imm, br_rs1, br_rs2, br_funct3, br_pred_taken,
    input  br_ready
  );

  modport slave (
    input  br_valid, br_pc, br_imm, br_rs1, br_rs2, br_funct3, br_pred_taken,
    output br_ready
  );
endinterface

// File: rtl/branch_resolve_ctrl.sv
// Resolves one RV32I conditional branch at a time, trains a 2-bit BHT for IF
// predictions, and redirects/flushes the front end on a misprediction.
module branch_resolve_ctrl #(
  parameter int BHT_IDX_W    = 6,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  branch_resolve_ctrl_if.slave        br,
  input  logic [31:0]                 if_pc,
  output logic                        if_pred_taken,
  output logic                        redirect_valid,
  output logic [31:0]                 redirect_pc,
  output logic                        flush,
  output logic                        illegal_br,
  output logic [15:0]                 branch_cnt,
  output logic [15:0]                 mispredict_cnt
);

  typedef enum logic [1:0] {IDLE, EVAL, FLUSH} state_t;

  localparam int         BHT_N      = 1 << BHT_IDX_W;
  localparam logic [3:0] FLUSH_LAST = 4'(FLUSH_CYCLES - 1);

  state_t      state;
  logic        ready_q;
  logic [3:0]  flush_cnt;
  logic [31:0] pc_q, imm_q, rs1_q, rs2_q;
  logic [2:0]  funct3_q;
  logic        pred_q;

  logic [1:0]  bht [BHT_N];

  logic                 taken;
  logic                 legal;
  logic                 mispredict;
  logic [31:0]          target;
  logic [31:0]          fallthrough;
  logic [BHT_IDX_W-1:0] upd_idx;
  logic                 unused_if_pc_bits;

  // Condition is evaluated on the captured operands; illegal funct3 resolves not-taken.
  always_comb begin
    taken = 1'b0;
    legal = 1'b1;
    case (funct3_q)
      3'b000:  taken = (rs1_q == rs2_q);
      3'b001:  taken = (rs1_q != rs2_q);
      3'b100:  taken = ($signed(rs1_q) <  $signed(rs2_q));
      3'b101:  taken = ($signed(rs1_q) >= $signed(rs2_q));
      3'b110:  taken = (rs1_q <  rs2_q);
      3'b111:  taken = (rs1_q >= rs2_q);
      default: legal = 1'b0;
    endcase
  end

  assign mispredict  = (taken != pred_q);
  assign target      = pc_q + imm_q;
  assign fallthrough = pc_q + 32'd4;
  assign upd_idx     = pc_q[BHT_IDX_W+1:2];

  assign if_pred_taken     = bht[if_pc[BHT_IDX_W+1:2]][1];
  assign unused_if_pc_bits = ^{if_pc[31:BHT_IDX_W+2], if_pc[1:0]};

  assign br.br_ready = ready_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_N; i++) bht[i] <= 2'b01;
    end else if (state == EVAL && legal) begin
      if (taken && bht[upd_idx] != 2'b11)
        bht[upd_idx] <= bht[upd_idx] + 2'd1;
      else if (!taken && bht[upd_idx] != 2'b00)
        bht[upd_idx] <= bht[upd_idx] - 2'd1;
    end
  end

  // flush_cnt counts the remaining FLUSH cycles after the current one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      ready_q        <= 1'b1;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      flush          <= 1'b0;
      illegal_br     <= 1'b0;
      branch_cnt     <= '0;
      mispredict_cnt <= '0;
      flush_cnt      <= '0;
      pc_q           <= '0;
      imm_q          <= '0;
      rs1_q          <= '0;
      rs2_q          <= '0;
      funct3_q       <= '0;
      pred_q         <= 1'b0;
    end else begin
      redirect_valid <= 1'b0;
      illegal_br     <= 1'b0;
      case (state)
        IDLE: begin
          if (br.br_valid) begin
            pc_q     <= br.br_pc;
            imm_q    <= br.br_imm;
            rs1_q    <= br.br_rs1;
            rs2_q    <= br.br_rs2;
            funct3_q <= br.br_funct3;
            pred_q   <= br.br_pred_taken;
            ready_q  <= 1'b0;
            state    <= EVAL;
          end
        end
        EVAL: begin
          illegal_br <= !legal;
          if (legal) begin
            if (branch_cnt != 16'hFFFF) branch_cnt <= branch_cnt + 16'd1;
            if (mispredict && mispredict_cnt != 16'hFFFF)
              mispredict_cnt <= mispredict_cnt + 16'd1;
          end
          if (mispredict) begin
            redirect_pc    <= taken ? target : fallthrough;
            redirect_valid <= 1'b1;
            flush          <= 1'b1;
            flush_cnt      <= FLUSH_LAST;
            state          <= FLUSH;
          end else begin
            ready_q <= 1'b1;
            state   <= IDLE;
          end
        end
        FLUSH: begin
          if (flush_cnt == 4'd0) begin
            flush   <= 1'b0;
            ready_q <= 1'b1;
            state   <= IDLE;
          end else begin
            flush_cnt <= flush_cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/branch_resolve_ctrl.md
Name: branch_resolve_ctrl

Overview:
- Sequences branch resolution in the EX stage. It accepts one conditional branch at a time over a valid/ready handshake and evaluates the RV32I branch condition on its own registered copy of the operands.
- It maintains a 2-bit-counter branch history table (BHT) that supplies IF-stage predictions.
- On a misprediction it issues a redirect and holds a flush for a fixed number of cycles.

Parameters:
- BHT_IDX_W, 6, log2 of BHT entries (64 entries), indexed by pc[BHT_IDX_W+1:2].
- FLUSH_CYCLES, 2, cycles flush stays high after a mispredict (legal range 1..15).

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- br_valid  input  1  EX presents a branch
- br_ready  output  1  controller can accept a branch
- br_pc  input  32  branch instruction PC
- br_imm  input  32  sign-extended B-type offset
- br_rs1  input  32  source operand 1
- br_rs2  input  32  source operand 2
- br_funct3  input  3  RV32I funct3 (000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU)
- br_pred_taken  input  1  prediction IF used for this branch
- if_pc  input  32  IF-stage lookup PC
- if_pred_taken  output  1  prediction for if_pc
- redirect_valid  output  1  one-cycle pulse: fetch from redirect_pc
- redirect_pc  output  32  corrected fetch address
- flush  output  1  squash younger instructions in IF/ID
- illegal_br  output  1  one-cycle pulse: funct3 010/011 received
- branch_cnt  output  16  resolved legal branches, saturating
- mispredict_cnt  output  16  mispredicted legal branches, saturating

Behaviour:
- Reset (async, rst_n=0): state=IDLE; br_ready=1; redirect_valid=0; redirect_pc=0; flush=0; illegal_br=0; both counters=0; every BHT entry=2'b01 (weakly not-taken). Reset asserted mid-flush aborts the flush immediately.

FSM has three states: IDLE, EVAL, FLUSH.
- IDLE:
  - br_ready=1.
  - When br_valid=1, capture pc, imm, rs1, rs2, funct3 and pred_taken into registers, then go to EVAL.
- EVAL:
  - br_ready=0. Lasts exactly one cycle.
  - Compute taken from the registered operands. BLT/BGE use a signed compare; BLTU/BGEU use an unsigned compare.
  - Compute target = pc + imm (mod 2^32) and fallthrough = pc + 4 (mod 2^32).
  - Legal funct3, at the clock edge ending EVAL:
    - Update the BHT entry with a saturating counter: taken increments (saturates at 11), not-taken decrements (saturates at 00).
    - Increment branch_cnt.
    - mispredict = (taken != pred_taken). If mispredict:
      - increment mispredict_cnt;
      - redirect_pc = taken ? target : fallthrough;
      - redirect_valid=1 and flush=1 for the next cycle;
      - go to FLUSH.
    - Otherwise return to IDLE.
  - Illegal funct3 (010/011):
    - Treated as not-taken.
    - illegal_br=1 for the next cycle.
    - No BHT update and no counter change.
    - Mispredict check still applies with taken=0.
- FLUSH:
  - br_ready=0; flush=1 for FLUSH_CYCLES consecutive cycles, starting the cycle after EVAL.
  - redirect_valid is high only in the first FLUSH cycle.
  - redirect_pc holds its value until the next mispredict.
  - After the last flush cycle, return to IDLE.
- Throughput:
  - Correctly predicted branch: one accept every 2 cycles.
  - Mispredicted branch: one accept every 2 + FLUSH_CYCLES cycles.
- br_valid outside IDLE is ignored; no capture occurs.
- if_pred_taken = BHT[if_pc[BHT_IDX_W+1:2]][1], combinational. When a lookup and an update hit the same entry in the same cycle, the lookup returns the pre-update value.
- Counters saturate at 16'hFFFF. Counter updates happen simultaneously with the BHT update.
- Aliasing is permitted: PCs differing only above bit BHT_IDX_W+1 share an entry.

Test Plan:
- Reset, then look up any if_pc -> if_pred_taken=0. Outputs: br_ready=1, flush=0, both counters 0.
- BEQ, rs1=rs2=5, pc=0x100, imm=0x20, pred=0 -> in cycle EVAL+1: redirect_valid=1, redirect_pc=0x120. Then flush=1 for 2 cycles, mispredict_cnt=1, branch_cnt=1, BHT[0] becomes 10, and lookup if_pc=0x100 returns 1.
- BLT, rs1=0xFFFFFFFF, rs2=1, pred=1 -> taken and correct: no flush, br_ready=1 two cycles after accept. BLTU on the same operands with pred=1 -> not-taken: redirect_pc=pc+4.
- BGEU branch, taken, issued 4 times at pc=0x40 -> BHT[16] saturates at 11. Then 4 not-taken -> saturates at 00. branch_cnt=8.
- funct3=3'b010, pred=1 -> illegal_br pulse, redirect to pc+4, counters unchanged, BHT unchanged. Same with pred=0 -> illegal_br pulse only.
- Assert rst_n=0 during the second flush cycle -> flush=0 and state=IDLE immediately. After release, all BHT entries read 01.
